// File: rtl/cosim_retire_scheduler_pkg.sv
// cosim_retire_scheduler_pkg: retire record type, scheduler states and op-count limit
`ifndef COSIM_MAX_OP
`define COSIM_MAX_OP 8
`endif
package cosim_retire_scheduler_pkg;
  typedef logic [63:0] reg_t;
  typedef logic [63:0] insn_bits_t;
  typedef logic [7:0] uint8_t;
  localparam int unsigned cosim_max_op = `COSIM_MAX_OP;
  typedef struct packed {
    reg_t pc;
    insn_bits_t ir;
    uint8_t op_num;
  } cs_retire_t;
  typedef enum logic [1:0] {cs_sch_idle, cs_sch_issue, cs_sch_wait, cs_sch_halt} cs_sched_state_t;
endpackage

// File: rtl/cosim_retire_scheduler_fifo.sv
// cosim_retire_fifo: one hart's retire record FIFO (clk, rst, push, pop, din -> dout, full, empty)
module cosim_retire_fifo
  import cosim_retire_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  cs_retire_t din,
  output cs_retire_t dout,
  output logic       full,
  output logic       empty
);
  localparam int aw = $clog2(DEPTH);
  cs_retire_t mem [DEPTH];
  logic [aw:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {aw{1'b0}}};
  assign dout = mem[rd_ptr[aw-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[aw-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (aw+1)'(push && !full);
      rd_ptr <= rd_ptr + (aw+1)'(pop && !empty);
    end
endmodule

// File: rtl/cosim_retire_scheduler.sv
// cosim_retire_scheduler: buffers per-hart retire records, round-robins them onto the checker, halts on mismatch/timeout
module cosim_retire_scheduler
  import cosim_retire_scheduler_pkg::*;
#(
  parameter int NUM_HARTS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_HARTS-1:0]   ret_valid,
  output logic [NUM_HARTS-1:0]   ret_ready,
  input  logic [64*NUM_HARTS-1:0] ret_pc,
  input  logic [64*NUM_HARTS-1:0] ret_ir,
  input  logic [8*NUM_HARTS-1:0]  ret_opnum,
  output logic                   chk_req_valid,
  input  logic                   chk_req_ready,
  output logic [7:0]             chk_pid,
  output logic [63:0]            chk_pc,
  output logic [63:0]            chk_ir,
  output logic [7:0]             chk_opnum,
  input  logic                   chk_rsp_valid,
  input  logic                   chk_rsp_mismatch,
  output logic                   halt,
  output logic [7:0]             halt_pid,
  output logic                   timeout_err,
  output logic                   opnum_err,
  output logic [63:0]            retired_cnt
);
  cs_sched_state_t state;
  cs_retire_t head [NUM_HARTS];
  cs_retire_t sel;
  logic [NUM_HARTS-1:0] full, empty, push, pop, bad_op;
  logic [7:0] ptr, grant;
  logic any;
  logic [31:0] timer;
  assign ret_ready = ~full & {NUM_HARTS{!(rst || halt)}};
  assign push = ret_valid & ret_ready;
  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    assign pop[g] = state == cs_sch_issue && chk_req_ready && chk_pid == 8'(g);
    assign bad_op[g] = ret_opnum[8*g+:8] > 8'(cosim_max_op);
    cosim_retire_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push[g]),
      .pop(pop[g]),
      .din('{pc: ret_pc[64*g+:64], ir: ret_ir[64*g+:64], op_num: ret_opnum[8*g+:8]}),
      .dout(head[g]),
      .full(full[g]),
      .empty(empty[g])
    );
  end
  // First pass takes harts above ptr, second pass wraps to the bottom.
  always_comb begin
    grant = ptr;
    sel = head[0];
    any = 1'b0;
    for (int h = 0; h < NUM_HARTS; h++)
      if (!empty[h] && !any && h > int'(ptr)) begin
        grant = 8'(h);
        sel = head[h];
        any = 1'b1;
      end
    for (int h = 0; h < NUM_HARTS; h++)
      if (!empty[h] && !any) begin
        grant = 8'(h);
        sel = head[h];
        any = 1'b1;
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= cs_sch_idle;
      ptr <= 8'(NUM_HARTS-1);
      chk_req_valid <= 1'b0;
      chk_pid <= '0;
      chk_pc <= '0;
      chk_ir <= '0;
      chk_opnum <= '0;
      halt <= 1'b0;
      halt_pid <= '0;
      timeout_err <= 1'b0;
      opnum_err <= 1'b0;
      retired_cnt <= '0;
      timer <= '0;
    end else begin
      if (|(push & bad_op)) opnum_err <= 1'b1;
      case (state)
        cs_sch_idle:
          if (any) begin
            chk_req_valid <= 1'b1;
            chk_pid <= grant;
            chk_pc <= sel.pc;
            chk_ir <= sel.ir;
            chk_opnum <= sel.op_num;
            ptr <= grant;
            state <= cs_sch_issue;
          end
        cs_sch_issue:
          if (chk_req_ready) begin
            chk_req_valid <= 1'b0;
            timer <= '0;
            state <= cs_sch_wait;
          end
        cs_sch_wait:
          if (chk_rsp_valid && !chk_rsp_mismatch) begin
            retired_cnt <= retired_cnt + 64'd1;
            state <= cs_sch_idle;
          end else if (chk_rsp_valid || timer == 32'(TIMEOUT-1)) begin
            halt <= 1'b1;
            halt_pid <= chk_pid;
            timeout_err <= !chk_rsp_valid;
            state <= cs_sch_halt;
          end else timer <= timer + 32'd1;
        default: state <= cs_sch_halt;
      endcase
    end
endmodule

// File: tb/tb_cosim_retire_scheduler.sv
// tb_cosim_retire_scheduler: directed self-checking bench for cosim_retire_scheduler
module tb_cosim_retire_scheduler;
  import cosim_retire_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] ret_valid = '0;
  logic [1:0] ret_ready;
  logic [127:0] ret_pc = '0;
  logic [127:0] ret_ir = '0;
  logic [15:0] ret_opnum = '0;
  logic chk_req_valid;
  logic chk_req_ready = 1'b0;
  logic [7:0] chk_pid;
  logic [63:0] chk_pc, chk_ir;
  logic [7:0] chk_opnum;
  logic chk_rsp_valid = 1'b0;
  logic chk_rsp_mismatch = 1'b0;
  logic halt;
  logic [7:0] halt_pid;
  logic timeout_err, opnum_err;
  logic [63:0] retired_cnt;
  int vectors = 0;
  int miscompares = 0;
  cosim_retire_scheduler #(.NUM_HARTS(2), .FIFO_DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk),
    .rst(rst),
    .ret_valid(ret_valid),
    .ret_ready(ret_ready),
    .ret_pc(ret_pc),
    .ret_ir(ret_ir),
    .ret_opnum(ret_opnum),
    .chk_req_valid(chk_req_valid),
    .chk_req_ready(chk_req_ready),
    .chk_pid(chk_pid),
    .chk_pc(chk_pc),
    .chk_ir(chk_ir),
    .chk_opnum(chk_opnum),
    .chk_rsp_valid(chk_rsp_valid),
    .chk_rsp_mismatch(chk_rsp_mismatch),
    .halt(halt),
    .halt_pid(halt_pid),
    .timeout_err(timeout_err),
    .opnum_err(opnum_err),
    .retired_cnt(retired_cnt)
  );
  always #5 clk = ~clk;
  // Producer side: a valid bit drops once its record has been accepted.
  task automatic tick();
    logic [1:0] acc;
    @(negedge clk);
    acc = ret_valid & ret_ready;
    @(posedge clk);
    #1;
    ret_valid = ret_valid & ~acc;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    ret_valid = '0;
    chk_req_ready = 1'b0;
    chk_rsp_valid = 1'b0;
    chk_rsp_mismatch = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask
  task automatic wait_req(input string tag);
    int n = 0;
    while (!chk_req_valid && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (chk_req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s req_wait: chk_req_valid=%b want 1 after %0d cycles", tag, chk_req_valid, n);
    end
  endtask
  task automatic respond(input logic mm);
    chk_req_ready = 1'b1;
    tick();
    chk_req_ready = 1'b0;
    chk_rsp_valid = 1'b1;
    chk_rsp_mismatch = mm;
    tick();
    chk_rsp_valid = 1'b0;
    chk_rsp_mismatch = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++;
    if ({chk_req_valid, halt, timeout_err, opnum_err, ret_ready, retired_cnt, chk_pid, halt_pid} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b halt=%b to=%b op=%b rdy=%b cnt=%0d pid=%0d hpid=%0d want all 0",
               chk_req_valid, halt, timeout_err, opnum_err, ret_ready, retired_cnt, chk_pid, halt_pid);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (ret_ready !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready: ret_ready=%b want 11", ret_ready);
    end
  endtask
  task automatic test_single();
    ret_valid = 2'b01;
    ret_pc[63:0] = 64'h8000_0000;
    ret_ir[63:0] = 64'h0000_0013;
    ret_opnum[7:0] = 8'd1;
    tick();
    vectors++;
    if (chk_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: chk_req_valid=%b want 0 one cycle after push", chk_req_valid);
    end
    tick();
    vectors++;
    if ({chk_req_valid, chk_pid, chk_pc, chk_ir, chk_opnum} !== {1'b1, 8'd0, 64'h8000_0000, 64'h13, 8'd1}) begin
      miscompares++;
      $display("FAIL single_req: valid=%b pid=%0d pc=%h ir=%h op=%0d want 1/0/80000000/13/1",
               chk_req_valid, chk_pid, chk_pc, chk_ir, chk_opnum);
    end
    chk_req_ready = 1'b1;
    tick();
    chk_req_ready = 1'b0;
    vectors++;
    if (chk_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wait: chk_req_valid=%b want 0 in WAIT", chk_req_valid);
    end
    chk_rsp_valid = 1'b1;
    tick();
    chk_rsp_valid = 1'b0;
    vectors++;
    if (retired_cnt !== 64'd1) begin
      miscompares++;
      $display("FAIL single_cnt: retired_cnt=%0d want 1", retired_cnt);
    end
  endtask
  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ret_valid = 2'b11;
      ret_pc[63:0] = 64'h1000 + 64'(k);
      ret_pc[127:64] = 64'h1100 + 64'(k);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      wait_req("rr");
      vectors++;
      if (chk_pid !== 8'(i % 2) || chk_pc !== 64'h1000 + 64'h100 * 64'(i % 2) + 64'(i / 2)) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: pid=%0d pc=%h want pid=%0d pc=%h", i, chk_pid, chk_pc,
                 i % 2, 64'h1000 + 64'h100 * 64'(i % 2) + 64'(i / 2));
      end
      respond(1'b0);
    end
    vectors++;
    if (retired_cnt !== 64'd6) begin
      miscompares++;
      $display("FAIL rr_cnt: retired_cnt=%0d want 6", retired_cnt);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ret_valid[1] = 1'b1;
      ret_pc[127:64] = 64'h2000 + 64'(k);
      vectors++;
      if (ret_ready[1] !== (k < 4)) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: ret_ready[1]=%b want %b", k, ret_ready[1], k < 4);
      end
      tick();
    end
    vectors++;
    if (ret_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_full: ret_ready=%b want 01", ret_ready);
    end
    for (int k = 0; k < 5; k++) begin
      wait_req("b2b");
      vectors++;
      if (chk_pid !== 8'd1 || chk_pc !== 64'h2000 + 64'(k)) begin
        miscompares++;
        $display("FAIL b2b_order[%0d]: pid=%0d pc=%h want pid=1 pc=%h", k, chk_pid, chk_pc, 64'h2000 + 64'(k));
      end
      respond(1'b0);
    end
    vectors++;
    if (retired_cnt !== 64'd5) begin
      miscompares++;
      $display("FAIL b2b_cnt: retired_cnt=%0d want 5", retired_cnt);
    end
  endtask
  task automatic test_mismatch();
    logic seen;
    do_reset();
    ret_valid = 2'b10;
    ret_pc[127:64] = 64'h3000;
    ret_opnum[15:8] = 8'(cosim_max_op + 1);
    tick();
    ret_valid = 2'b10;
    ret_pc[127:64] = 64'h3001;
    ret_opnum[15:8] = 8'd2;
    tick();
    vectors++;
    if (opnum_err !== 1'b1) begin
      miscompares++;
      $display("FAIL opnum_err: opnum_err=%b want 1", opnum_err);
    end
    wait_req("mm0");
    vectors++;
    if (chk_pid !== 8'd1 || chk_pc !== 64'h3000 || chk_opnum !== 8'(cosim_max_op + 1)) begin
      miscompares++;
      $display("FAIL mm_first: pid=%0d pc=%h op=%0d want 1/3000/%0d", chk_pid, chk_pc, chk_opnum, cosim_max_op + 1);
    end
    respond(1'b0);
    wait_req("mm1");
    vectors++;
    if (chk_pc !== 64'h3001) begin
      miscompares++;
      $display("FAIL mm_second: pc=%h want 3001", chk_pc);
    end
    respond(1'b1);
    vectors++;
    if ({halt, halt_pid, ret_ready, retired_cnt, timeout_err} !== {1'b1, 8'd1, 2'b00, 64'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL mm_halt: halt=%b hpid=%0d rdy=%b cnt=%0d to=%b want 1/1/00/1/0",
               halt, halt_pid, ret_ready, retired_cnt, timeout_err);
    end
    seen = 1'b0;
    ret_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= chk_req_valid;
    end
    ret_valid = 2'b00;
    vectors++;
    if (seen !== 1'b0 || halt !== 1'b1) begin
      miscompares++;
      $display("FAIL mm_absorb: req_seen=%b halt=%b want 0/1", seen, halt);
    end
  endtask
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      ret_valid = 2'b01;
      ret_pc[63:0] = 64'h5000;
      ret_opnum[7:0] = 8'd0;
      tick();
      wait_req("to");
      chk_req_ready = 1'b1;
      tick();
      chk_req_ready = 1'b0;
      for (int i = 1; i < 8; i++) tick();
      vectors++;
      if (halt !== 1'b0) begin
        miscompares++;
        $display("FAIL to_early[%0d]: halt=%b want 0 during WAIT cycle 8", pass, halt);
      end
      chk_rsp_valid = pass == 1;
      tick();
      chk_rsp_valid = 1'b0;
      vectors++;
      if (pass == 0 && {halt, timeout_err, halt_pid} !== {1'b1, 1'b1, 8'd0}) begin
        miscompares++;
        $display("FAIL to_fire: halt=%b to=%b hpid=%0d want 1/1/0", halt, timeout_err, halt_pid);
      end
      if (pass == 1 && {halt, timeout_err, retired_cnt} !== {1'b0, 1'b0, 64'd1}) begin
        miscompares++;
        $display("FAIL to_race: halt=%b to=%b cnt=%0d want 0/0/1", halt, timeout_err, retired_cnt);
      end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    ret_valid = 2'b10;
    ret_pc[127:64] = 64'h6000;
    ret_opnum[15:8] = 8'hff;
    tick();
    ret_valid = 2'b10;
    ret_pc[127:64] = 64'h6001;
    ret_opnum[15:8] = 8'd0;
    tick();
    wait_req("rm");
    chk_req_ready = 1'b1;
    tick();
    chk_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    vectors++;
    if ({chk_req_valid, halt, opnum_err, ret_ready, retired_cnt, chk_pid, chk_pc} !== '0) begin
      miscompares++;
      $display("FAIL rm_reset: req=%b halt=%b op=%b rdy=%b cnt=%0d pid=%0d pc=%h want all 0",
               chk_req_valid, halt, opnum_err, ret_ready, retired_cnt, chk_pid, chk_pc);
    end
    rst = 1'b0;
    ret_valid = 2'b11;
    ret_pc[63:0] = 64'h6100;
    ret_pc[127:64] = 64'h6200;
    tick();
    wait_req("rm0");
    vectors++;
    if (chk_pid !== 8'd0 || chk_pc !== 64'h6100) begin
      miscompares++;
      $display("FAIL rm_first: pid=%0d pc=%h want 0/6100", chk_pid, chk_pc);
    end
    respond(1'b0);
    wait_req("rm1");
    vectors++;
    if (chk_pid !== 8'd1 || chk_pc !== 64'h6200) begin
      miscompares++;
      $display("FAIL rm_second: pid=%0d pc=%h want 1/6200", chk_pid, chk_pc);
    end
    respond(1'b0);
    vectors++;
    if (retired_cnt !== 64'd2 || chk_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_drain: cnt=%0d req=%b want 2/0", retired_cnt, chk_req_valid);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
